// File: rtl/tama_pkg.sv
// Shared definitions for the button-event front end: event indices, event code
// layout and the press FSM state encoding.
package tama_pkg;

   localparam int unsigned NUM_BTN      = 4;
   localparam int unsigned EVT_LONG_BIT = 2;

   localparam logic [1:0] EVT_FEED  = 2'd0;
   localparam logic [1:0] EVT_PLAY  = 2'd1;
   localparam logic [1:0] EVT_CLEAN = 2'd2;
   localparam logic [1:0] EVT_SLEEP = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } press_state_e;

   function automatic logic [2:0] make_evt(input logic is_long, input logic [1:0] idx);
      logic [2:0] code;
      code               = {1'b0, idx};
      code[EVT_LONG_BIT] = is_long;
      return code;
   endfunction

endpackage

// File: rtl/tama_debounce.sv
// One button: 2-flop synchroniser followed by a stability counter that toggles
// the debounced level after DEBOUNCE_CYCLES consecutive disagreeing samples.
module tama_debounce
   import tama_pkg::*;
#(
   parameter int unsigned      CNT_W           = 16,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic raw,
   output logic level
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] DB_LAST  = DEBOUNCE_CYCLES - CNT_ONE;

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Debounce counter and level toggle; frozen while disabled.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (!ena) begin
         level_d = level_q;
         cnt_d   = cnt_q;
      end else if (sync2_q == level_q) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q == DB_LAST) begin
         level_d = ~level_q;
         cnt_d   = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchroniser runs regardless of ena.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= CNT_ZERO;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/tama_button_events.sv
// Button front end: debounce, short/long press classification, per-button pending
// slots, lowest-index arbiter and a 2-deep event FIFO. Long presses are built only
// when TAMA_LONG_PRESS_EN is defined.
module tama_button_events
   import tama_pkg::*;
#(
   parameter int unsigned      CNT_W           = 16,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [CNT_W-1:0] LONG_CYCLES     = 16'd60000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [2:0] evt_code,
   output logic       overflow
);

   logic [NUM_BTN-1:0] level_s;
   logic [NUM_BTN-1:0] raise_s, raise_long_s;
   press_state_e       state_q [NUM_BTN];
   press_state_e       state_d [NUM_BTN];

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      tama_debounce #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .ena   (ena),
         .raw   (btn_raw[g]),
         .level (level_s[g])
      );
   end

   assign btn_level = level_s;

`ifdef TAMA_LONG_PRESS_EN
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HOLD_LAST = LONG_CYCLES - CNT_ONE;

   logic [CNT_W-1:0] hold_q [NUM_BTN];
   logic [CNT_W-1:0] hold_d [NUM_BTN];

   // Press FSMs with hold counter; the counter saturates by leaving HELD.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         state_d[i]      = state_q[i];
         hold_d[i]       = hold_q[i];
         raise_s[i]      = 1'b0;
         raise_long_s[i] = 1'b0;
         if (ena) begin
            case (state_q[i])
               ST_IDLE: begin
                  if (level_s[i]) begin
                     state_d[i] = ST_HELD;
                     hold_d[i]  = {CNT_W{1'b0}};
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end
               ST_HELD: begin
                  if (!level_s[i]) begin
                     state_d[i] = ST_IDLE;
                     raise_s[i] = 1'b1;
                  end else if (hold_q[i] == HOLD_LAST) begin
                     state_d[i]      = ST_LONG;
                     raise_s[i]      = 1'b1;
                     raise_long_s[i] = 1'b1;
                  end else begin
                     hold_d[i] = hold_q[i] + CNT_ONE;
                  end
               end
               ST_LONG: begin
                  if (!level_s[i]) begin
                     state_d[i] = ST_IDLE;
                  end else begin
                     state_d[i] = ST_LONG;
                  end
               end
               default: state_d[i] = ST_IDLE;
            endcase
         end else begin
            state_d[i] = state_q[i];
         end
      end
   end

   // Hold counter registers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BTN; i++) begin
         if (rst) begin
            hold_q[i] <= {CNT_W{1'b0}};
         end else begin
            hold_q[i] <= hold_d[i];
         end
      end
   end
`else
   // Press FSMs without long detection: every release is a short event.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         state_d[i]      = state_q[i];
         raise_s[i]      = 1'b0;
         raise_long_s[i] = 1'b0;
         if (ena) begin
            case (state_q[i])
               ST_IDLE: begin
                  if (level_s[i]) begin
                     state_d[i] = ST_HELD;
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end
               ST_HELD: begin
                  if (!level_s[i]) begin
                     state_d[i] = ST_IDLE;
                     raise_s[i] = 1'b1;
                  end else begin
                     state_d[i] = ST_HELD;
                  end
               end
               default: state_d[i] = ST_IDLE;
            endcase
         end else begin
            state_d[i] = state_q[i];
         end
      end
   end
`endif

   // Press FSM state registers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BTN; i++) begin
         if (rst) begin
            state_q[i] <= ST_IDLE;
         end else begin
            state_q[i] <= state_d[i];
         end
      end
   end

   logic [NUM_BTN-1:0] pend_q, pend_d, pend_long_q, pend_long_d;
   logic [NUM_BTN-1:0] take_s;
   logic [2:0]         head_q, head_d, tail_q, tail_d, push_code_s;
   logic [1:0]         count_q, count_d;
   logic               ovf_q, ovf_d, pop_s, push_s, can_push_s;

   // Pending slots, lowest-index arbiter and the 2-entry FIFO (head/tail registers).
   always_comb begin
      pop_s       = (count_q != 2'd0) && evt_ready;
      can_push_s  = (count_q != 2'd2) || pop_s;
      take_s      = can_push_s ? (pend_q & (~pend_q + 4'd1)) : 4'd0;
      push_s      = |take_s;
      push_code_s = 3'b000;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (take_s[i]) begin
            push_code_s = make_evt(pend_long_q[i], 2'(i));
         end else begin
            push_code_s = push_code_s;
         end
      end

      pend_d      = pend_q & ~take_s;
      pend_long_d = pend_long_q;
      ovf_d       = ovf_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (raise_s[i] && pend_q[i]) begin
            ovf_d = 1'b1;
         end else if (raise_s[i]) begin
            pend_d[i]      = 1'b1;
            pend_long_d[i] = raise_long_s[i];
         end else begin
            pend_d[i] = pend_d[i];
         end
      end

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = push_code_s;
            end else begin
               tail_d = push_code_s;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_code_s;
            end else begin
               head_d = tail_q;
               tail_d = push_code_s;
            end
         end
         default: count_d = count_q;
      endcase
   end

   // Queue and overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 4'd0;
         pend_long_q <= 4'd0;
         head_q      <= 3'd0;
         tail_q      <= 3'd0;
         count_q     <= 2'd0;
         ovf_q       <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_long_q <= pend_long_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   assign evt_valid = (count_q != 2'd0);
   assign evt_code  = head_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_tama_button_events.sv
// Bench for tama_button_events: directed scenarios followed by random button and
// consumer activity, all checked cycle by cycle against a timestamp/queue model.
`timescale 1ns/1ps
module tb_tama_button_events;

   localparam int D  = 4;
   localparam int LC = 20;
`ifdef TAMA_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, ena, evt_ready;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic       evt_valid, overflow;
   logic [2:0] evt_code;

   always #5 clk = ~clk;

   tama_button_events #(
      .CNT_W           (16),
      .DEBOUNCE_CYCLES (16'd4),
      .LONG_CYCLES     (16'd20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .overflow  (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (value after the most recent clock edge)
   logic [3:0] m_s1, m_s2, m_lvl, m_pend, m_pend_long;
   int         m_run   [4];
   bit         m_held  [4];
   bit         m_longed[4];
   int         m_since [4];
   bit         m_ovf;
   logic [2:0] m_q[$];
   int         t = 0;
   logic [2:0] obs[$];
   bit         saw;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 4'd0; m_s2 = 4'd0; m_lvl = 4'd0; m_pend = 4'd0; m_pend_long = 4'd0;
      m_ovf = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0; m_held[i] = 1'b0; m_longed[i] = 1'b0; m_since[i] = 0;
      end
   endtask

   task automatic model_step();
      logic [3:0] raise, raise_long, old_pend;
      bit         pop, can_push;
      int         sel;
      t++;
      if (rst) begin
         model_reset();
         return;
      end
      raise = 4'd0; raise_long = 4'd0;
      if (ena) begin
         for (int i = 0; i < 4; i++) begin
            if (!m_held[i] && m_lvl[i]) begin
               m_held[i] = 1'b1; m_since[i] = t; m_longed[i] = 1'b0;
            end else if (m_held[i] && !m_lvl[i]) begin
               m_held[i] = 1'b0;
               if (!m_longed[i]) raise[i] = 1'b1;
               m_longed[i] = 1'b0;
            end else if (m_held[i] && LONG_EN && !m_longed[i] && (t - m_since[i] == LC)) begin
               m_longed[i] = 1'b1; raise[i] = 1'b1; raise_long[i] = 1'b1;
            end
            if (m_s2[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_lvl[i] = ~m_lvl[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;

      old_pend = m_pend;
      pop      = (m_q.size() != 0) && evt_ready;
      can_push = (m_q.size() < 2) || pop;
      sel = -1;
      if (can_push) for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
      if (pop) void'(m_q.pop_front());
      if (sel >= 0) begin
         m_q.push_back({m_pend_long[sel], 2'(sel)});
         m_pend[sel] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (raise[i]) begin
            if (old_pend[i]) m_ovf = 1'b1;
            else begin
               m_pend[i] = 1'b1;
               m_pend_long[i] = raise_long[i];
            end
         end
      end
   endtask

   task automatic tick();
      if (evt_valid && evt_ready && !rst) obs.push_back(evt_code);
      @(posedge clk);
      model_step();
      #1;
      check("btn_level", btn_level, m_lvl);
      check("evt_valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("evt_code", evt_code, m_q[0]);
      check("overflow", overflow, m_ovf);
      if (btn_level[1]) saw = 1'b1;
   endtask

   task automatic press(input int idx, input int hi, input int lo);
      btn_raw[idx] = 1'b1;
      repeat (hi) tick();
      btn_raw[idx] = 1'b0;
      repeat (lo) tick();
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; evt_ready = 1'b1; btn_raw = 4'd0;
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      check("rst_code", evt_code, 3'b000);
      check("rst_level", btn_level, 4'd0);

      // Short press on FEED
      obs.delete();
      btn_raw[0] = 1'b1;
      repeat (5) tick();
      check("lvl0_pre", btn_level[0], 1'b0);
      tick();
      check("lvl0_rise", btn_level[0], 1'b1);
      repeat (4) tick();
      btn_raw[0] = 1'b0;
      repeat (15) tick();
      check("short_cnt", obs.size(), 1);
      check("short_code", (obs.size() > 0) ? obs[0] : 3'bxxx, 3'b000);

      // Bounce on PLAY
      obs.delete(); saw = 1'b0;
      for (int k = 0; k < 12; k++) begin
         btn_raw[1] = ((k / 2) % 2) == 0;
         tick();
      end
      btn_raw[1] = 1'b0;
      repeat (12) tick();
      check("bounce_lvl", saw, 1'b0);
      check("bounce_evt", obs.size(), 0);

      // Long press on SLEEP
      obs.delete();
      btn_raw[3] = 1'b1;
      repeat (40) tick();
      check("long_held_cnt", obs.size(), LONG_EN ? 1 : 0);
      if (LONG_EN) check("long_code", (obs.size() > 0) ? obs[0] : 3'bxxx, 3'b111);
      btn_raw[3] = 1'b0;
      repeat (15) tick();
      check("long_rel_cnt", obs.size(), 1);
      check("long_rel_code", (obs.size() > 0) ? obs[0] : 3'bxxx, LONG_EN ? 3'b111 : 3'b011);

      // Simultaneous releases with a stalled consumer
      obs.delete();
      btn_raw = 4'hF;
      repeat (10) tick();
      evt_ready = 1'b0;
      btn_raw = 4'h0;
      repeat (12) tick();
      check("sim_valid", evt_valid, 1'b1);
      check("sim_head", evt_code, 3'b000);
      evt_ready = 1'b1;
      repeat (8) tick();
      check("sim_cnt", obs.size(), 4);
      for (int k = 0; k < 4; k++) check("sim_order", (obs.size() > k) ? obs[k] : 3'bxxx, 3'(k));
      check("sim_ovf", overflow, 1'b0);

      // ena low freezes debounce
      obs.delete();
      ena = 1'b0;
      btn_raw[1] = 1'b1;
      repeat (10) tick();
      check("ena_frozen", btn_level[1], 1'b0);
      ena = 1'b1;
      repeat (5) tick();
      check("ena_resume", btn_level[1], 1'b1);
      btn_raw[1] = 1'b0;
      repeat (12) tick();
      check("ena_evt", (obs.size() > 0) ? obs[0] : 3'bxxx, 3'b001);

      // Overflow on CLEAN with consumer stalled
      evt_ready = 1'b0;
      press(0, 8, 8);
      press(2, 8, 8);
      press(2, 8, 8);
      check("ovf_pre", overflow, 1'b0);
      press(2, 8, 8);
      check("ovf_set", overflow, 1'b1);
      repeat (5) tick();
      check("ovf_sticky", overflow, 1'b1);

      // Reset mid-queue with SLEEP held through reset
      btn_raw[3] = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_valid", evt_valid, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_lvl", btn_level, 4'd0);
      obs.delete();
      evt_ready = 1'b1;
      repeat (10) tick();
      check("fresh_lvl", btn_level[3], 1'b1);
      btn_raw[3] = 1'b0;
      repeat (12) tick();
      check("fresh_evt", (obs.size() > 0) ? obs[0] : 3'bxxx, 3'b011);

      // Random activity against the model
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) btn_raw[i] = ~btn_raw[i];
         evt_ready = ($urandom_range(0, 3) != 0);
         ena       = ($urandom_range(0, 31) != 0);
         rst       = ($urandom_range(0, 599) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
